data_mem_responder: RTL and testbench

- Responder side of the pipeline's load/store interface. It sits behind the memory stage and owns the data RAM array.
- Accepts one request at a time over a valid/ready handshake.
- Stores: performs read-modify-write merging for byte and halfword stores.
- Loads: returns byte/halfword/word data, sign- or zero-extended, over a valid/ready response channel. Flags misaligned accesses instead of performing them.

---
 rtl/data_mem_responder.sv | 184 ++++++++++++++++++
 tb/tb_data_mem_responder.sv | 286 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/data_mem_responder.sv
// Purpose : load/store responder that owns the data RAM; does read-modify-write for
//           byte/half stores and returns sign/zero-extended load data.
// Latency : aligned request answers 3 cycles after the accept cycle; misaligned or
//           reserved-size requests answer 1 cycle after accept with no RAM access.
// Backpressure: one request in flight; out_req_ready stays low until the response has
//           been taken (out_resp_valid && in_resp_ready), and the response is held until then.
//
// Ports:
//   clk, reset          clock and synchronous active-high reset
//   in_req_valid        request present       out_req_ready   request accepted this cycle
//   in_addr             byte address (LE)     in_write_en     1 = store, 0 = load
//   in_size             00 byte/01 half/10 word/11 reserved
//   in_unsigned         zero-extend loads     in_wdata        store data (low lanes used)
//   out_resp_valid      response present      in_resp_ready   requester takes response
//   out_rdata           extended load data    out_misaligned  misaligned / reserved size
module data_mem_responder #(
   parameter int len   = 32,
   parameter int DEPTH = 2048,
   parameter int AW    = $clog2(DEPTH)
) (
   input  logic           clk,
   input  logic           reset,
   input  logic           in_req_valid,
   output logic           out_req_ready,
   input  logic [len-1:0] in_addr,
   input  logic           in_write_en,
   input  logic [1:0]     in_size,
   input  logic           in_unsigned,
   input  logic [len-1:0] in_wdata,
   output logic           out_resp_valid,
   input  logic           in_resp_ready,
   output logic [len-1:0] out_rdata,
   output logic           out_misaligned
);

   localparam logic [1:0] SZ_BYTE = 2'b00;
   localparam logic [1:0] SZ_HALF = 2'b01;
   localparam logic [1:0] SZ_WORD = 2'b10;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      READ   = 2'd1,
      MODIFY = 2'd2,
      RESP   = 2'd3
   } state_t;

   state_t state;

   // Request copies captured at accept; only these are used after the handshake.
   // Address bits above the word index are dropped so the index wraps modulo DEPTH.
   logic [AW+1:0]  addr_q;
   logic           we_q;
   logic [1:0]     size_q;
   logic           uns_q;
   logic [len-1:0] wdata_q;

   logic [len-1:0] mem [DEPTH];
   logic [len-1:0] rd_word;

   logic           accept;
   logic           req_misaligned;
   logic [AW-1:0]  idx_q;
   logic [1:0]     lane_q;
   logic [len-1:0] wr_word;
   logic [len-1:0] ld_data;
   logic [7:0]     byte_sel;
   logic [15:0]    half_sel;
   logic           ram_we;
   logic           unused_addr_hi;

   assign unused_addr_hi = ^in_addr[len-1:AW+2];

   assign out_req_ready = (state == IDLE) && !reset;
   assign accept        = in_req_valid && out_req_ready;

   // Reserved size is reported the same way as a misaligned access.
   always_comb begin
      req_misaligned = 1'b0;
      case (in_size)
         SZ_BYTE: req_misaligned = 1'b0;
         SZ_HALF: req_misaligned = in_addr[0];
         SZ_WORD: req_misaligned = (in_addr[1:0] != 2'b00);
         default: req_misaligned = 1'b1;
      endcase
   end

   assign idx_q  = addr_q[AW+1:2];
   assign lane_q = addr_q[1:0];

   // Store merge: replace only the addressed lane of the word fetched in READ.
   always_comb begin
      wr_word = rd_word;
      case (size_q)
         SZ_BYTE: wr_word[{lane_q, 3'b000} +: 8]     = wdata_q[7:0];
         SZ_HALF: wr_word[{lane_q[1], 4'b0000} +: 16] = wdata_q[15:0];
         default: wr_word = wdata_q;
      endcase
   end

   // Load extraction and extension.
   assign byte_sel = rd_word[{lane_q, 3'b000} +: 8];
   assign half_sel = rd_word[{lane_q[1], 4'b0000} +: 16];

   always_comb begin
      ld_data = rd_word;
      case (size_q)
         SZ_BYTE: ld_data = uns_q ? {{(len-8){1'b0}}, byte_sel}
                                  : {{(len-8){byte_sel[7]}}, byte_sel};
         SZ_HALF: ld_data = uns_q ? {{(len-16){1'b0}}, half_sel}
                                  : {{(len-16){half_sel[15]}}, half_sel};
         default: ld_data = rd_word;
      endcase
   end

   // A reset landing on the MODIFY edge must not let the store commit.
   assign ram_we = (state == MODIFY) && we_q && !reset;

   // RAM array: not reset, contents survive reset.
   always_ff @(posedge clk) begin
      if (state == READ) begin
         rd_word <= mem[idx_q];
      end
      if (ram_we) begin
         mem[idx_q] <= wr_word;
      end
   end

   // Control FSM with registered response outputs.
   always_ff @(posedge clk) begin
      if (reset) begin
         state          <= IDLE;
         out_resp_valid <= 1'b0;
         out_rdata      <= '0;
         out_misaligned <= 1'b0;
         addr_q         <= '0;
         we_q           <= 1'b0;
         size_q         <= SZ_BYTE;
         uns_q          <= 1'b0;
         wdata_q        <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (accept) begin
                  addr_q  <= in_addr[AW+1:0];
                  we_q    <= in_write_en;
                  size_q  <= in_size;
                  uns_q   <= in_unsigned;
                  wdata_q <= in_wdata;
                  if (req_misaligned) begin
                     // Skip the RAM entirely and answer next cycle.
                     out_misaligned <= 1'b1;
                     out_rdata      <= '0;
                     out_resp_valid <= 1'b1;
                     state          <= RESP;
                  end else begin
                     state <= READ;
                  end
               end
            end
            READ: begin
               state <= MODIFY;
            end
            MODIFY: begin
               out_rdata      <= we_q ? '0 : ld_data;
               out_misaligned <= 1'b0;
               out_resp_valid <= 1'b1;
               state          <= RESP;
            end
            RESP: begin
               if (in_resp_ready) begin
                  out_resp_valid <= 1'b0;
                  out_rdata      <= '0;
                  out_misaligned <= 1'b0;
                  state          <= IDLE;
               end
            end
            default: begin
               state <= IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_data_mem_responder.sv
// Purpose : scoreboard bench for data_mem_responder; directed requests push expected
//           responses, an independent monitor pops and compares on each response handshake.
// Latency : monitor also checks response latency (3 aligned, 1 misaligned) and hold stability.
// Backpressure: in_resp_ready is held low in one phase to exercise response stalling.
module tb_data_mem_responder;

   localparam int LEN   = 32;
   localparam int DEPTH = 2048;
   localparam logic [1:0] B = 2'b00, H = 2'b01, W = 2'b10, RSV = 2'b11;

   logic            clk = 1'b0;
   logic            reset;
   logic            in_req_valid;
   logic            out_req_ready;
   logic [LEN-1:0]  in_addr;
   logic            in_write_en;
   logic [1:0]      in_size;
   logic            in_unsigned;
   logic [LEN-1:0]  in_wdata;
   logic            out_resp_valid;
   logic            in_resp_ready;
   logic [LEN-1:0]  out_rdata;
   logic            out_misaligned;

   data_mem_responder #(.len(LEN), .DEPTH(DEPTH)) dut (
      .clk            (clk),
      .reset          (reset),
      .in_req_valid   (in_req_valid),
      .out_req_ready  (out_req_ready),
      .in_addr        (in_addr),
      .in_write_en    (in_write_en),
      .in_size        (in_size),
      .in_unsigned    (in_unsigned),
      .in_wdata       (in_wdata),
      .out_resp_valid (out_resp_valid),
      .in_resp_ready  (in_resp_ready),
      .out_rdata      (out_rdata),
      .out_misaligned (out_misaligned)
   );

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   int checks = 0;
   int errors = 0;

   typedef struct {
      string       name;
      logic [31:0] rdata;
      logic        mis;
      int          lat;
      int          acc;
   } exp_t;

   exp_t sb[$];
   int   last_hs  = -1;
   int   last_acc = -1;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%08h required 0x%08h", name, act, exp);
      end
   endtask

   // Monitor: all sampling on the falling edge.
   initial begin
      logic        prev_vld;
      logic [31:0] held_rdata;
      logic        held_mis;
      prev_vld   = 1'b0;
      held_rdata = '0;
      held_mis   = 1'b0;
      forever begin
         @(negedge clk);
         if (reset) begin
            prev_vld = 1'b0;
         end else begin
            if (out_resp_valid) begin
               if (sb.size() == 0) begin
                  checks++;
                  errors++;
                  $display("FAIL unexpected_resp: got valid with rdata 0x%08h, required no response", out_rdata);
               end else begin
                  if (!prev_vld) begin
                     check({sb[0].name, " latency"}, 32'(cyc - sb[0].acc), 32'(sb[0].lat));
                     held_rdata = out_rdata;
                     held_mis   = out_misaligned;
                  end else begin
                     check({sb[0].name, " hold_rdata"}, out_rdata, held_rdata);
                     check({sb[0].name, " hold_mis"}, 32'(out_misaligned), 32'(held_mis));
                  end
                  if (in_resp_ready) begin
                     check({sb[0].name, " rdata"}, out_rdata, sb[0].rdata);
                     check({sb[0].name, " misaligned"}, 32'(out_misaligned), 32'(sb[0].mis));
                     void'(sb.pop_front());
                     last_hs = cyc;
                  end
               end
            end
            prev_vld = out_resp_valid;
         end
      end
   end

   // Issue one request; the expected response is queued at the accept cycle.
   task automatic req(input string name, input logic [31:0] addr, input logic we,
                      input logic [1:0] size, input logic uns, input logic [31:0] wdata,
                      input logic [31:0] exp_rdata, input logic exp_mis);
      exp_t e;
      int   n;
      @(negedge clk);
      in_addr      = addr;
      in_write_en  = we;
      in_size      = size;
      in_unsigned  = uns;
      in_wdata     = wdata;
      in_req_valid = 1'b1;
      n = 0;
      while (!out_req_ready && n < 50) begin
         @(negedge clk);
         n++;
      end
      if (!out_req_ready) begin
         checks++;
         errors++;
         $display("FAIL %s accept_timeout: ready 0, required 1 within 50 cycles", name);
         in_req_valid = 1'b0;
         return;
      end
      e.name  = name;
      e.rdata = exp_rdata;
      e.mis   = exp_mis;
      e.lat   = exp_mis ? 1 : 3;
      e.acc   = cyc;
      sb.push_back(e);
      last_acc = cyc;
      @(negedge clk);
      // Scramble the bus after accept: the DUT must only use its captured copy.
      in_req_valid = 1'b0;
      in_addr      = $urandom;
      in_wdata     = $urandom;
      in_size      = 2'($urandom);
      in_write_en  = 1'($urandom);
      in_unsigned  = 1'($urandom);
   endtask

   task automatic drain();
      int n;
      n = 0;
      while (sb.size() != 0 && n < 100) begin
         @(negedge clk);
         n++;
      end
      checks++;
      if (sb.size() != 0) begin
         errors++;
         $display("FAIL drain: %0d responses outstanding, required 0", sb.size());
         sb.delete();
      end
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: run still active at 500000, required to finish earlier");
      $fatal(1, "watchdog expired");
   end

   initial begin
      int n;
      reset         = 1'b1;
      in_req_valid  = 1'b0;
      in_resp_ready = 1'b1;
      in_addr       = '0;
      in_write_en   = 1'b0;
      in_size       = B;
      in_unsigned   = 1'b0;
      in_wdata      = '0;

      repeat (3) @(negedge clk);
      check("rst_req_ready",  32'(out_req_ready), 32'd0);
      check("rst_resp_valid", 32'(out_resp_valid), 32'd0);
      check("rst_rdata",      out_rdata, 32'h0);
      check("rst_misaligned", 32'(out_misaligned), 32'd0);
      reset = 1'b0;
      @(negedge clk);
      check("post_rst_req_ready", 32'(out_req_ready), 32'd1);

      // Word store / load, then byte merge and byte extensions.
      req("st_w_10",   32'h10, 1'b1, W, 1'b0, 32'hDEADBEEF, 32'h0,        1'b0);
      req("ld_w_10",   32'h10, 1'b0, W, 1'b0, 32'h0,        32'hDEADBEEF, 1'b0);
      req("st_b_12",   32'h12, 1'b1, B, 1'b0, 32'hFFFFFF55, 32'h0,        1'b0);
      req("ld_w_10b",  32'h10, 1'b0, W, 1'b0, 32'h0,        32'hDE55BEEF, 1'b0);
      req("ld_b_13s",  32'h13, 1'b0, B, 1'b0, 32'h0,        32'hFFFFFFDE, 1'b0);
      req("ld_b_13u",  32'h13, 1'b0, B, 1'b1, 32'h0,        32'h000000DE, 1'b0);
      req("ld_b_12s",  32'h12, 1'b0, B, 1'b0, 32'h0,        32'h00000055, 1'b0);

      // Half store merge and half loads on both lanes.
      req("st_w_20",   32'h20, 1'b1, W, 1'b0, 32'hCAFE0000, 32'h0,        1'b0);
      req("st_h_20",   32'h20, 1'b1, H, 1'b0, 32'h12348001, 32'h0,        1'b0);
      req("ld_h_20s",  32'h20, 1'b0, H, 1'b0, 32'h0,        32'hFFFF8001, 1'b0);
      req("ld_h_20u",  32'h20, 1'b0, H, 1'b1, 32'h0,        32'h00008001, 1'b0);
      req("ld_h_22s",  32'h22, 1'b0, H, 1'b0, 32'h0,        32'hFFFFCAFE, 1'b0);
      req("ld_h_22u",  32'h22, 1'b0, H, 1'b1, 32'h0,        32'h0000CAFE, 1'b0);
      req("ld_w_20",   32'h20, 1'b0, W, 1'b0, 32'h0,        32'hCAFE8001, 1'b0);

      // Misaligned / reserved: fast error response, RAM untouched.
      req("mis_ld_w_06", 32'h06, 1'b0, W,   1'b0, 32'h0,        32'h0, 1'b1);
      req("mis_ld_h_05", 32'h05, 1'b0, H,   1'b0, 32'h0,        32'h0, 1'b1);
      req("mis_rsv_st",  32'h10, 1'b1, RSV, 1'b0, 32'hFFFFFFFF, 32'h0, 1'b1);
      req("mis_st_w_11", 32'h11, 1'b1, W,   1'b0, 32'h0,        32'h0, 1'b1);
      req("mis_st_h_13", 32'h13, 1'b1, H,   1'b0, 32'h0,        32'h0, 1'b1);
      req("ld_w_10c",    32'h10, 1'b0, W,   1'b0, 32'h0, 32'hDE55BEEF, 1'b0);
      drain();

      // Response held for 5 cycles while another request waits.
      @(posedge clk);
      #1 in_resp_ready = 1'b0;
      req("hold_ld_w_20", 32'h20, 1'b0, W, 1'b0, 32'h0, 32'hCAFE8001, 1'b0);
      fork
         req("b2b_ld_b_21s", 32'h21, 1'b0, B, 1'b0, 32'h0, 32'hFFFFFF80, 1'b0);
         begin
            n = 0;
            while (!out_resp_valid && n < 20) begin
               @(negedge clk);
               n++;
            end
            check("hold_valid_seen", 32'(out_resp_valid), 32'd1);
            repeat (5) begin
               check("hold_req_ready",  32'(out_req_ready), 32'd0);
               check("hold_resp_valid", 32'(out_resp_valid), 32'd1);
               @(negedge clk);
            end
            @(posedge clk);
            #1 in_resp_ready = 1'b1;
         end
      join
      check("b2b_accept_cycle", 32'(last_acc), 32'(last_hs + 1));
      drain();

      // Reset on the MODIFY cycle of a byte store: no write, no response.
      @(negedge clk);
      in_addr      = 32'h10;
      in_write_en  = 1'b1;
      in_size      = B;
      in_unsigned  = 1'b0;
      in_wdata     = 32'h00000000;
      in_req_valid = 1'b1;
      n = 0;
      while (!out_req_ready && n < 50) begin
         @(negedge clk);
         n++;
      end
      check("abort_accept", 32'(out_req_ready), 32'd1);
      @(negedge clk);             // READ
      in_req_valid = 1'b0;
      @(negedge clk);             // MODIFY
      reset = 1'b1;
      @(negedge clk);
      check("abort_rst_ready", 32'(out_req_ready), 32'd0);
      check("abort_rst_valid", 32'(out_resp_valid), 32'd0);
      reset = 1'b0;
      @(negedge clk);
      check("abort_post_ready", 32'(out_req_ready), 32'd1);
      repeat (3) begin
         check("abort_no_resp", 32'(out_resp_valid), 32'd0);
         @(negedge clk);
      end
      req("abort_ld_w_10", 32'h10, 1'b0, W, 1'b0, 32'h0, 32'hDE55BEEF, 1'b0);

      // Word index wraps modulo DEPTH.
      req("wrap_st_w",  DEPTH*4 + 32'h10, 1'b1, W, 1'b0, 32'h13579BDF, 32'h0,        1'b0);
      req("wrap_ld_w",  32'h10,           1'b0, W, 1'b0, 32'h0,        32'h13579BDF, 1'b0);
      req("wrap_st_b",  DEPTH*4 + 32'h13, 1'b1, B, 1'b0, 32'h000000A5, 32'h0,        1'b0);
      req("wrap_ld_w2", 32'h10,           1'b0, W, 1'b0, 32'h0,        32'hA5579BDF, 1'b0);
      drain();

      repeat (2) @(negedge clk);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
